// File: rtl/reservation_station_pkg.sv
// Shared widths, tag/opcode constants and operand record for the reservation station.
package reservation_station_pkg;

  localparam int RS_SIZE  = 16;
  localparam int RS_IDX_W = 4;
  localparam int ROB_ID_W = 4;
  localparam int DATA_W   = 32;
  localparam int OPENUM_W = 6;
  localparam int PC_W     = 32;

  typedef logic [RS_IDX_W-1:0] rs_idx_t;
  typedef logic [ROB_ID_W-1:0] rob_id_t;
  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [OPENUM_W-1:0] openum_t;
  typedef logic [PC_W-1:0]     pc_t;

  localparam rob_id_t ZERO_ROB   = '0;
  localparam openum_t OPENUM_NOP = '0;

  typedef struct packed {
    rob_id_t q;
    data_t   v;
  } operand_t;

endpackage

// File: rtl/rs_select.sv
// Priority pickers over the entry bitmaps: lowest free slot, lowest issuable slot, near-full flag.
module rs_select
  import reservation_station_pkg::*;
(
  input  logic [RS_SIZE-1:0] busy,
  input  logic [RS_SIZE-1:0] ready,
  output rs_idx_t            free_idx,
  output logic               has_free,
  output rs_idx_t            ready_idx,
  output logic               has_ready,
  output logic               almost_full
);

  always_comb begin
    free_idx  = '0;
    has_free  = 1'b0;
    ready_idx = '0;
    has_ready = 1'b0;
    // Scan downwards so the lowest index is the last (winning) assignment.
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_idx = rs_idx_t'(i);
        has_free = 1'b1;
      end
      if (ready[i]) begin
        ready_idx = rs_idx_t'(i);
        has_ready = 1'b1;
      end
    end
  end

  // One slot of margin covers the instruction already in the dispatcher's register.
  assign almost_full = ($countones(~busy) < 2);

endmodule

// File: rtl/reservation_station.sv
// Reservation station: buffers ALU/branch ops until both operands arrive, issues one per cycle.
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    rdy,
  input  logic    ena_from_dsp,
  input  openum_t openum_from_dsp,
  input  data_t   V1_from_dsp,
  input  data_t   V2_from_dsp,
  input  rob_id_t Q1_from_dsp,
  input  rob_id_t Q2_from_dsp,
  input  pc_t     pc_from_dsp,
  input  data_t   imm_from_dsp,
  input  rob_id_t rob_id_from_dsp,
  output logic    full_to_if,
  input  logic    valid_alu_cdb,
  input  rob_id_t rob_id_alu_cdb,
  input  data_t   result_alu_cdb,
  input  logic    valid_ls_cdb,
  input  rob_id_t rob_id_ls_cdb,
  input  data_t   result_ls_cdb,
  input  logic    misbranch_flag,
  output logic    ena_to_alu,
  output openum_t openum_to_alu,
  output data_t   V1_to_alu,
  output data_t   V2_to_alu,
  output pc_t     pc_to_alu,
  output data_t   imm_to_alu,
  output rob_id_t rob_id_to_alu
);

  logic [RS_SIZE-1:0] busy_p0;
  logic [RS_SIZE-1:0] ready_p0;
  logic [RS_SIZE-1:0] issue_mask;
  logic [RS_SIZE-1:0] ins_mask;
  openum_t            op_p0   [RS_SIZE];
  data_t              v1_p0   [RS_SIZE];
  data_t              v2_p0   [RS_SIZE];
  rob_id_t            q1_p0   [RS_SIZE];
  rob_id_t            q2_p0   [RS_SIZE];
  pc_t                pc_p0   [RS_SIZE];
  data_t              imm_p0  [RS_SIZE];
  rob_id_t            rob_p0  [RS_SIZE];
  operand_t           wake1   [RS_SIZE];
  operand_t           wake2   [RS_SIZE];
  operand_t           op1_in;
  operand_t           op2_in;
  rs_idx_t            free_idx;
  rs_idx_t            ready_idx;
  logic               has_free;
  logic               has_ready;

  // Snoop both CDBs for a pending tag; ALU wins when both carry it, tag 0 never matches.
  function automatic operand_t capture(
    input rob_id_t q, input data_t v,
    input logic av, input rob_id_t at, input data_t ar,
    input logic lv, input rob_id_t lt, input data_t lr
  );
    operand_t r;
    r = '{q: q, v: v};
    if (q != ZERO_ROB) begin
      if (av && at == q)      r = '{q: ZERO_ROB, v: ar};
      else if (lv && lt == q) r = '{q: ZERO_ROB, v: lr};
    end
    return r;
  endfunction

  assign op1_in = capture(Q1_from_dsp, V1_from_dsp, valid_alu_cdb, rob_id_alu_cdb,
                          result_alu_cdb, valid_ls_cdb, rob_id_ls_cdb, result_ls_cdb);
  assign op2_in = capture(Q2_from_dsp, V2_from_dsp, valid_alu_cdb, rob_id_alu_cdb,
                          result_alu_cdb, valid_ls_cdb, rob_id_ls_cdb, result_ls_cdb);

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_p0[i]   = busy_p0[i] && q1_p0[i] == ZERO_ROB && q2_p0[i] == ZERO_ROB;
      wake1[i]      = capture(q1_p0[i], v1_p0[i], valid_alu_cdb, rob_id_alu_cdb,
                              result_alu_cdb, valid_ls_cdb, rob_id_ls_cdb, result_ls_cdb);
      wake2[i]      = capture(q2_p0[i], v2_p0[i], valid_alu_cdb, rob_id_alu_cdb,
                              result_alu_cdb, valid_ls_cdb, rob_id_ls_cdb, result_ls_cdb);
      issue_mask[i] = has_ready && ready_idx == rs_idx_t'(i);
      ins_mask[i]   = ena_from_dsp && has_free && free_idx == rs_idx_t'(i);
    end
  end

  rs_select u_select (
    .busy        (busy_p0),
    .ready       (ready_p0),
    .free_idx    (free_idx),
    .has_free    (has_free),
    .ready_idx   (ready_idx),
    .has_ready   (has_ready),
    .almost_full (full_to_if)
  );

  // Stage p0 -> issue register: busy tracking and the ALU-facing outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_p0       <= '0;
      ena_to_alu    <= 1'b0;
      openum_to_alu <= OPENUM_NOP;
      V1_to_alu     <= '0;
      V2_to_alu     <= '0;
      pc_to_alu     <= '0;
      imm_to_alu    <= '0;
      rob_id_to_alu <= '0;
    end else if (rdy) begin
      if (misbranch_flag) begin
        busy_p0    <= '0;
        ena_to_alu <= 1'b0;
      end else begin
        busy_p0    <= (busy_p0 & ~issue_mask) | ins_mask;
        ena_to_alu <= has_ready;
        if (has_ready) begin
          openum_to_alu <= op_p0[ready_idx];
          V1_to_alu     <= v1_p0[ready_idx];
          V2_to_alu     <= v2_p0[ready_idx];
          pc_to_alu     <= pc_p0[ready_idx];
          imm_to_alu    <= imm_p0[ready_idx];
          rob_id_to_alu <= rob_p0[ready_idx];
        end
      end
    end
  end

  // Entry payload: insert into the chosen free slot, otherwise apply CDB wakeup.
  always_ff @(posedge clk) begin
    if (rdy && !misbranch_flag) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (ins_mask[i]) begin
          op_p0[i]  <= openum_from_dsp;
          v1_p0[i]  <= op1_in.v;
          q1_p0[i]  <= op1_in.q;
          v2_p0[i]  <= op2_in.v;
          q2_p0[i]  <= op2_in.q;
          pc_p0[i]  <= pc_from_dsp;
          imm_p0[i] <= imm_from_dsp;
          rob_p0[i] <= rob_id_from_dsp;
        end else if (busy_p0[i]) begin
          v1_p0[i]  <= wake1[i].v;
          q1_p0[i]  <= wake1[i].q;
          v2_p0[i]  <= wake2[i].v;
          q2_p0[i]  <= wake2[i].q;
        end
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: vector table, directed corner sequences, random run vs. model.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic    clk, rst, rdy, ena_from_dsp, full_to_if;
  openum_t openum_from_dsp, openum_to_alu;
  data_t   V1_from_dsp, V2_from_dsp, imm_from_dsp;
  rob_id_t Q1_from_dsp, Q2_from_dsp, rob_id_from_dsp;
  pc_t     pc_from_dsp, pc_to_alu;
  logic    valid_alu_cdb, valid_ls_cdb, misbranch_flag, ena_to_alu;
  rob_id_t rob_id_alu_cdb, rob_id_ls_cdb, rob_id_to_alu;
  data_t   result_alu_cdb, result_ls_cdb, V1_to_alu, V2_to_alu, imm_to_alu;

  reservation_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .ena_from_dsp(ena_from_dsp),
    .openum_from_dsp(openum_from_dsp), .V1_from_dsp(V1_from_dsp), .V2_from_dsp(V2_from_dsp),
    .Q1_from_dsp(Q1_from_dsp), .Q2_from_dsp(Q2_from_dsp), .pc_from_dsp(pc_from_dsp),
    .imm_from_dsp(imm_from_dsp), .rob_id_from_dsp(rob_id_from_dsp), .full_to_if(full_to_if),
    .valid_alu_cdb(valid_alu_cdb), .rob_id_alu_cdb(rob_id_alu_cdb), .result_alu_cdb(result_alu_cdb),
    .valid_ls_cdb(valid_ls_cdb), .rob_id_ls_cdb(rob_id_ls_cdb), .result_ls_cdb(result_ls_cdb),
    .misbranch_flag(misbranch_flag), .ena_to_alu(ena_to_alu), .openum_to_alu(openum_to_alu),
    .V1_to_alu(V1_to_alu), .V2_to_alu(V2_to_alu), .pc_to_alu(pc_to_alu),
    .imm_to_alu(imm_to_alu), .rob_id_to_alu(rob_id_to_alu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: a slot table plus the last issued instruction.
  typedef struct {
    logic    busy;
    openum_t op;
    data_t   v1, v2;
    rob_id_t q1, q2;
    pc_t     pc;
    data_t   imm;
    rob_id_t rob;
  } ment_t;

  ment_t m [RS_SIZE];
  ment_t m_out;
  logic  m_ena;

  task automatic model_reset();
    for (int i = 0; i < RS_SIZE; i++) m[i].busy = 1'b0;
    m_out = '{busy: 1'b0, op: OPENUM_NOP, v1: 0, v2: 0, q1: 0, q2: 0, pc: 0, imm: 0, rob: 0};
    m_ena = 1'b0;
  endtask

  task automatic resolve(inout rob_id_t q, inout data_t v);
    if (q != 0) begin
      if (valid_alu_cdb && q == rob_id_alu_cdb) begin v = result_alu_cdb; q = 0; end
      else if (valid_ls_cdb && q == rob_id_ls_cdb) begin v = result_ls_cdb; q = 0; end
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    ment_t   nxt [RS_SIZE];
    ment_t   e;
    int      iss, fr;
    rob_id_t tq;
    data_t   tv;
    if (!rst) begin model_reset(); return; end
    if (!rdy) return;
    if (misbranch_flag) begin
      for (int i = 0; i < RS_SIZE; i++) m[i].busy = 1'b0;
      m_ena = 1'b0;
      return;
    end
    nxt = m;
    iss = -1;
    fr  = -1;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (iss < 0 && m[i].busy && m[i].q1 == 0 && m[i].q2 == 0) iss = i;
      if (fr < 0 && !m[i].busy) fr = i;
      if (m[i].busy) begin
        tq = nxt[i].q1; tv = nxt[i].v1; resolve(tq, tv); nxt[i].q1 = tq; nxt[i].v1 = tv;
        tq = nxt[i].q2; tv = nxt[i].v2; resolve(tq, tv); nxt[i].q2 = tq; nxt[i].v2 = tv;
      end
    end
    m_ena = (iss >= 0);
    if (iss >= 0) begin
      m_out = m[iss];
      nxt[iss].busy = 1'b0;
    end
    if (ena_from_dsp && fr >= 0) begin
      e = '{busy: 1'b1, op: openum_from_dsp, v1: V1_from_dsp, v2: V2_from_dsp,
            q1: Q1_from_dsp, q2: Q2_from_dsp, pc: pc_from_dsp, imm: imm_from_dsp,
            rob: rob_id_from_dsp};
      tq = e.q1; tv = e.v1; resolve(tq, tv); e.q1 = tq; e.v1 = tv;
      tq = e.q2; tv = e.v2; resolve(tq, tv); e.q2 = tq; e.v2 = tv;
      nxt[fr] = e;
    end
    m = nxt;
  endtask

  function automatic logic model_full();
    int n = 0;
    for (int i = 0; i < RS_SIZE; i++) if (!m[i].busy) n++;
    return n < 2;
  endfunction

  task automatic compare_model();
    chk("mdl_ena", ena_to_alu, m_ena);
    chk("mdl_op", openum_to_alu, m_out.op);
    chk("mdl_v1", V1_to_alu, m_out.v1);
    chk("mdl_v2", V2_to_alu, m_out.v2);
    chk("mdl_pc", pc_to_alu, m_out.pc);
    chk("mdl_imm", imm_to_alu, m_out.imm);
    chk("mdl_rob", rob_id_to_alu, m_out.rob);
    chk("mdl_full", full_to_if, model_full());
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic idle();
    rdy = 1'b1; ena_from_dsp = 1'b0; misbranch_flag = 1'b0;
    valid_alu_cdb = 1'b0; valid_ls_cdb = 1'b0;
  endtask

  task automatic ins(input rob_id_t q1, input rob_id_t q2, input data_t v1, input data_t v2,
                     input rob_id_t rob);
    ena_from_dsp = 1'b1; openum_from_dsp = 6'd3;
    Q1_from_dsp = q1; Q2_from_dsp = q2; V1_from_dsp = v1; V2_from_dsp = v2;
    pc_from_dsp = 32'h1000 + 32'(rob); imm_from_dsp = 32'h40 + 32'(rob); rob_id_from_dsp = rob;
  endtask

  task automatic alu_cdb(input rob_id_t t, input data_t r);
    valid_alu_cdb = 1'b1; rob_id_alu_cdb = t; result_alu_cdb = r;
  endtask

  task automatic flush();
    idle(); misbranch_flag = 1'b1; tick(); idle();
  endtask

  typedef struct {
    rob_id_t q1, q2;
    data_t   v1, v2;
    logic    av; rob_id_t at; data_t ar;
    logic    lv; rob_id_t lt; data_t lr;
    logic    exp_ena;
    data_t   exp_v1, exp_v2;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{0, 0, 3,     4,     0, 0, 0,     0, 0, 0,      1, 3,     4};
    vecs[1] = '{0, 9, 'h11,  0,     0, 0, 0,     1, 9, 'hABCD, 1, 'h11,  'hABCD};
    vecs[2] = '{7, 0, 0,     'h22,  1, 7, 'h100, 0, 0, 0,      1, 'h100, 'h22};
    vecs[3] = '{5, 5, 0,     0,     1, 5, 'hAA,  1, 5, 'hBB,   1, 'hAA,  'hAA};
    vecs[4] = '{3, 0, 0,     1,     1, 4, 'h44,  0, 0, 0,      0, 0,     0};
    vecs[5] = '{0, 0, 'h77,  'h88,  1, 0, 'hDEAD, 1, 0, 'hBEEF, 1, 'h77,  'h88};
    vecs[6] = '{2, 6, 0,     0,     1, 2, 'h222, 1, 6, 'h666,  1, 'h222, 'h666};
    vecs[7] = '{0, 8, 5,     0,     0, 8, 'h99,  0, 0, 0,      0, 0,     0};

    rst = 1'b0;
    idle();
    ins(0, 0, 0, 0, 0);
    ena_from_dsp = 1'b0;
    rob_id_alu_cdb = 0; result_alu_cdb = 0; rob_id_ls_cdb = 0; result_ls_cdb = 0;
    model_reset();
    #12;
    chk("rst_ena", ena_to_alu, 1'b0);
    chk("rst_op", openum_to_alu, OPENUM_NOP);
    chk("rst_v1", V1_to_alu, 0);
    chk("rst_full", full_to_if, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Single-instruction vectors, including same-cycle CDB bypass cases.
    for (int k = 0; k < 8; k++) begin
      ins(vecs[k].q1, vecs[k].q2, vecs[k].v1, vecs[k].v2, rob_id_t'(k + 1));
      valid_alu_cdb = vecs[k].av; rob_id_alu_cdb = vecs[k].at; result_alu_cdb = vecs[k].ar;
      valid_ls_cdb = vecs[k].lv; rob_id_ls_cdb = vecs[k].lt; result_ls_cdb = vecs[k].lr;
      tick();
      idle();
      tick();
      chk($sformatf("vec%0d_ena", k), ena_to_alu, vecs[k].exp_ena);
      if (vecs[k].exp_ena) begin
        chk($sformatf("vec%0d_v1", k), V1_to_alu, vecs[k].exp_v1);
        chk($sformatf("vec%0d_v2", k), V2_to_alu, vecs[k].exp_v2);
        chk($sformatf("vec%0d_rob", k), rob_id_to_alu, k + 1);
      end
      tick();
      chk($sformatf("vec%0d_ena_once", k), ena_to_alu, 1'b0);
      flush();
    end

    // Late wakeup from the ALU CDB two cycles after insert.
    ins(7, 0, 0, 32'h5, 4'd2); tick();
    idle(); tick(); chk("late_ena0", ena_to_alu, 1'b0);
    alu_cdb(7, 32'h100); tick(); chk("late_ena1", ena_to_alu, 1'b0);
    idle(); tick();
    chk("late_ena2", ena_to_alu, 1'b1);
    chk("late_v1", V1_to_alu, 32'h100);

    // Fill to 15 blocked entries, then wake one.
    for (int k = 0; k < 15; k++) begin
      ins(rob_id_t'(k + 1), 0, 0, 0, rob_id_t'(k));
      tick();
      chk($sformatf("fill%0d_full", k), full_to_if, (k + 1) >= 15);
    end
    idle(); alu_cdb(5, 32'h55); tick();
    chk("wake_ena0", ena_to_alu, 1'b0);
    chk("wake_full1", full_to_if, 1'b1);
    idle(); tick();
    chk("wake_ena1", ena_to_alu, 1'b1);
    chk("wake_v1", V1_to_alu, 32'h55);
    chk("wake_rob", rob_id_to_alu, 4);
    chk("wake_full0", full_to_if, 1'b0);
    flush();

    // Three ready entries killed by a flush, then a freeze while issue is visible.
    for (int k = 0; k < 3; k++) begin ins(6, 0, 0, 0, rob_id_t'(k)); tick(); end
    idle(); alu_cdb(6, 32'h66); tick();
    idle(); misbranch_flag = 1'b1; tick();
    chk("mb_ena", ena_to_alu, 1'b0);
    chk("mb_full", full_to_if, 1'b0);
    idle();
    for (int k = 0; k < 3; k++) begin tick(); chk("mb_noissue", ena_to_alu, 1'b0); end
    ins(0, 0, 32'hF00D, 32'h1, 4'd3); tick();
    idle(); tick();
    chk("frz_pre_ena", ena_to_alu, 1'b1);
    rdy = 1'b0; ins(0, 0, 32'hBAD, 0, 4'd7);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("frz_ena", ena_to_alu, 1'b1);
      chk("frz_v1", V1_to_alu, 32'hF00D);
      chk("frz_rob", rob_id_to_alu, 3);
    end
    idle(); tick();
    chk("frz_post_ena", ena_to_alu, 1'b0);

    // Asynchronous reset with five busy entries and an issue in flight.
    for (int k = 0; k < 5; k++) begin ins(8, 0, 0, 0, rob_id_t'(k)); tick(); end
    ins(0, 0, 32'h5A, 0, 4'd9); tick();
    idle(); tick();
    chk("ar_pre_ena", ena_to_alu, 1'b1);
    rst = 1'b0;
    #1;
    model_reset();
    chk("ar_ena", ena_to_alu, 1'b0);
    chk("ar_full", full_to_if, 1'b0);
    chk("ar_v1", V1_to_alu, 0);
    #2;
    rst = 1'b1;
    alu_cdb(8, 32'h88); tick();
    chk("ar_noissue0", ena_to_alu, 1'b0);
    idle(); tick(); chk("ar_noissue1", ena_to_alu, 1'b0);
    ins(0, 0, 32'h321, 0, 4'd1); tick();
    idle(); tick();
    chk("ar_new_ena", ena_to_alu, 1'b1);
    chk("ar_new_v1", V1_to_alu, 32'h321);

    // Random traffic against the model; inserts ignore full to exercise drops.
    for (int n = 0; n < 800; n++) begin
      rdy            = ($urandom_range(0, 9) != 0);
      misbranch_flag = ($urandom_range(0, 59) == 0);
      ena_from_dsp   = ($urandom_range(0, 9) < 7);
      openum_from_dsp = openum_t'($urandom_range(0, 63));
      Q1_from_dsp    = ($urandom_range(0, 2) == 0) ? 4'd0 : rob_id_t'($urandom_range(1, 15));
      Q2_from_dsp    = ($urandom_range(0, 2) == 0) ? 4'd0 : rob_id_t'($urandom_range(1, 15));
      V1_from_dsp    = $urandom; V2_from_dsp = $urandom;
      pc_from_dsp    = $urandom; imm_from_dsp = $urandom;
      rob_id_from_dsp = rob_id_t'($urandom_range(0, 15));
      valid_alu_cdb  = (n < 150) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
      rob_id_alu_cdb = rob_id_t'($urandom_range(0, 15)); result_alu_cdb = $urandom;
      valid_ls_cdb   = (n < 150) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
      rob_id_ls_cdb  = rob_id_t'($urandom_range(0, 15)); result_ls_cdb = $urandom;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
